// File: rtl/inout_port.sv
// Bidirectional pad driver: direction FSM with receive-to-drive turnaround,
// registered output data and a receive synchronizer that always samples the pad.
module inout_port #(
    parameter int SYNC_STAGES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic outline,
    input  logic control,
    output logic inline,
    inout  wire  portline
);

    typedef enum logic [1:0] {RX, TA, TX} state_t;

    localparam logic [3:0] TA_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    state_t                 state_q, state_d;
    logic                   oe_q;
    logic                   out_q;
    logic [3:0]             ta_cnt, ta_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;

    always_comb begin
        state_d  = state_q;
        ta_cnt_d = ta_cnt;
        case (state_q)
            RX: if (control) begin
                if (TURNAROUND == 0) begin
                    state_d = TX;
                end else begin
                    state_d  = TA;
                    ta_cnt_d = TA_LOAD;
                end
            end
            TA: if (!control)           state_d  = RX;
                else if (ta_cnt == 4'd0) state_d  = TX;
                else                    ta_cnt_d = ta_cnt - 4'd1;
            TX: if (!control)           state_d  = RX;
            default:                    state_d  = RX;
        endcase
    end

    // oe_q is registered from the next state so it is high exactly in TX
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
            ta_cnt  <= 4'd0;
            sync_q  <= '0;
        end else begin
            state_q   <= state_d;
            oe_q      <= (state_d == TX);
            out_q     <= outline;
            ta_cnt    <= ta_cnt_d;
            sync_q[0] <= portline;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign portline = oe_q ? out_q : 1'bz;
    assign inline   = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_inout_port.sv
// Directed bench for inout_port: scoreboard of (due cycle, signal, value) entries
// checked one cycle at a time. Pad lines carry pull-ups so a released pad reads 1.
module tb_inout_port;

    logic clk = 1'b0;
    logic rst, outline, control, inl;
    logic tb_en, tb_val;
    logic ctl2, inl2;
    logic out2 = 1'b0;
    wire  portline, portline2;

    pullup (portline);
    pullup (portline2);
    assign portline = tb_en ? tb_val : 1'bz;

    inout_port #(.SYNC_STAGES(2), .TURNAROUND(1)) dut (
        .clk(clk), .rst(rst), .outline(outline), .control(control),
        .inline(inl), .portline(portline)
    );

    inout_port #(.SYNC_STAGES(2), .TURNAROUND(3)) dut3 (
        .clk(clk), .rst(rst), .outline(out2), .control(ctl2),
        .inline(inl2), .portline(portline2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    due;
        int    sel;   // 0 portline, 1 inline, 2 portline2
        logic  val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] pat = 8'b10101010;

    task automatic exp_at(input int n, input int sel, input logic val, input string tag);
        exp_t e;
        e.due = cyc + n; e.sel = sel; e.val = val; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_due();
        int   i;
        logic obs;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                case (sb[i].sel)
                    0:       obs = portline;
                    1:       obs = inl;
                    default: obs = portline2;
                endcase
                n_cmp++;
                assert (obs === sb[i].val) else begin
                    n_err++;
                    $error("FAIL %s cyc=%0d observed=%b expected=%b", sb[i].tag, cyc, obs, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    initial begin
        int a;
        rst = 1'b1; control = 1'b0; outline = 1'b0; tb_en = 1'b0; tb_val = 1'b0; ctl2 = 1'b0;

        // reset: both pads released, inline cleared
        exp_at(1, 0, 1'b1, "rst_pl");
        exp_at(1, 1, 1'b0, "rst_in");
        exp_at(1, 2, 1'b1, "rst_pl2");
        tick; tick;
        rst = 1'b0;
        // pulled-up idle pad reaches inline after two stages
        exp_at(1, 1, 1'b0, "post_rst_in0");
        exp_at(2, 1, 1'b1, "idle_in1");
        tick; tick; tick;

        // RX->TX: one high-Z turnaround cycle even though out_q is 0
        control = 1'b1; outline = 1'b0;
        exp_at(1, 0, 1'b1, "ta_hiz");
        tick;
        for (int i = 0; i < 8; i++) begin
            outline = pat[i];
            exp_at(1, 0, pat[i], "tx_pl");
            exp_at(3, 1, pat[i], "tx_echo");
            tick;
        end

        // TX->RX: released on the next edge
        control = 1'b0; outline = 1'b0;
        exp_at(1, 0, 1'b1, "tx2rx_rel");
        tick;

        // receive: bench drives, DUT holds the opposite value in out_q
        tb_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tb_val  = pat[i];
            outline = ~pat[i];
            exp_at(1, 0, pat[i], "rx_pl");
            exp_at(2, 1, pat[i], "rx_in");
            tick;
        end
        tb_en = 1'b0;
        tick; tick; tick;

        // reset mid-transmit
        control = 1'b1; outline = 1'b0;
        exp_at(1, 0, 1'b1, "rt_ta");
        exp_at(2, 0, 1'b0, "rt_tx");
        exp_at(3, 0, 1'b0, "rt_tx2");
        tick; tick; tick;
        rst = 1'b1;
        #1;
        n_cmp++;
        assert (portline === 1'b0) else begin
            n_err++;
            $error("FAIL rst_before_edge cyc=%0d observed=%b expected=%b", cyc, portline, 1'b0);
        end
        exp_at(1, 0, 1'b1, "rst_mid_rel");
        exp_at(1, 1, 1'b0, "rst_mid_in");
        tick;
        rst = 1'b0;
        exp_at(1, 0, 1'b1, "restart_ta");
        exp_at(1, 1, 1'b0, "restart_in");
        exp_at(2, 0, 1'b0, "restart_tx");
        tick; tick;
        control = 1'b0;
        tick;

        // TURNAROUND=3: abort after two cycles, pad never driven
        ctl2 = 1'b1;
        exp_at(1, 2, 1'b1, "abort_ta1");
        tick;
        exp_at(1, 2, 1'b1, "abort_ta2");
        tick;
        ctl2 = 1'b0;
        exp_at(1, 2, 1'b1, "abort_rx1");
        exp_at(2, 2, 1'b1, "abort_rx2");
        tick; tick;
        // a fresh request must take the full turnaround from RX
        ctl2 = 1'b1;
        for (a = 1; a <= 3; a++) exp_at(a, 2, 1'b1, "ta3_hiz");
        exp_at(4, 2, 1'b0, "ta3_drive");
        tick; tick; tick; tick;
        ctl2 = 1'b0;
        tick; tick;

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain observed=%0d expected=%0d", sb.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
